// File: rtl/player_pkg.sv
// Shared player definitions: action FSM state encodings and default frame
// constants, so the hitbox and collision logic agree on attack timing.
package player_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_MOVE        = 3'd1,
      ST_JUMP        = 3'd2,
      ST_ATK_STARTUP = 3'd3,
      ST_ATK_ACTIVE  = 3'd4,
      ST_ATK_RECOVER = 3'd5,
      ST_HITSTUN     = 3'd6
   } act_state_t;

   localparam int unsigned DEF_CNT_WIDTH      = 5;
   localparam int unsigned DEF_ATK_STARTUP    = 3;
   localparam int unsigned DEF_ATK_ACTIVE     = 2;
   localparam int unsigned DEF_ATK_RECOVERY   = 6;
   localparam int unsigned DEF_HITSTUN_FRAMES = 12;
   localparam int unsigned DEF_JUMP_TIMEOUT   = 24;
   // Tail of hitstun during which an attack press may be buffered.
   localparam int unsigned ATK_BUF_WINDOW     = 4;

   // Counter value of the last frame of a phase; a length of 0 acts as 1.
   function automatic int unsigned last_frame(input int unsigned frames);
      return (frames == 0) ? 0 : frames - 1;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter for the action FSM: clears on request, otherwise counts up
// one per frame strobe and saturates at all-ones.
//   clk, reset : clock, asynchronous active-high reset
//   scen       : frame strobe qualifying every update
//   clear      : load zero on the next strobe
//   count      : current frame count within the phase
module frame_timer #(
   parameter int unsigned CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 scen,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (scen) begin
         if (clear) begin
            count <= '0;
         end else if (count != {CNT_WIDTH{1'b1}}) begin
            count <= count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer: arbitrates move, jump, attack and hit
// reaction, runs the attack frame timeline and hitstun lockout, and drives
// the mover. All updates happen on the frame strobe SCEN.
// Optional build macro ATTACK_BUFFER_EN: buffers one attack press made during
// recovery, jump or the tail of hitstun and replays it on return to IDLE/MOVE.
// Inputs : clk, reset (async, active-high), SCEN, btn_left, btn_right,
//          btn_jump, btn_attack, hit_taken, jump_active
// Outputs: move_enable, move_left, move_right, jump, hitbox_active,
//          act_state[2:0], busy (all registered)
module player_action_ctrl
   import player_pkg::*;
#(
   parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int unsigned ATK_STARTUP    = DEF_ATK_STARTUP,
   parameter int unsigned ATK_ACTIVE     = DEF_ATK_ACTIVE,
   parameter int unsigned ATK_RECOVERY   = DEF_ATK_RECOVERY,
   parameter int unsigned HITSTUN_FRAMES = DEF_HITSTUN_FRAMES,
   parameter int unsigned JUMP_TIMEOUT   = DEF_JUMP_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SCEN,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       btn_attack,
   input  logic       hit_taken,
   input  logic       jump_active,
   output logic       move_enable,
   output logic       move_left,
   output logic       move_right,
   output logic       jump,
   output logic       hitbox_active,
   output logic [2:0] act_state,
   output logic       busy
);

   localparam logic [CNT_WIDTH-1:0] TC_STARTUP = CNT_WIDTH'(last_frame(ATK_STARTUP));
   localparam logic [CNT_WIDTH-1:0] TC_ACTIVE  = CNT_WIDTH'(last_frame(ATK_ACTIVE));
   localparam logic [CNT_WIDTH-1:0] TC_RECOVER = CNT_WIDTH'(last_frame(ATK_RECOVERY));
   localparam logic [CNT_WIDTH-1:0] TC_HITSTUN = CNT_WIDTH'(last_frame(HITSTUN_FRAMES));
   localparam logic [CNT_WIDTH-1:0] TC_JUMP    = CNT_WIDTH'(last_frame(JUMP_TIMEOUT));

   act_state_t           state, state_n;
   logic [CNT_WIDTH-1:0] cnt, term_sel;
   logic                 cnt_term, cnt_clr, restart;
   logic                 atk_prev, atk_press, atk_go, takeoff;
   logic                 jump_seen, jump_seen_n;
   logic                 move_enable_n, move_left_n, move_right_n;
   logic                 jump_n, hitbox_n, busy_n;

   frame_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
      .clk   (clk),
      .reset (reset),
      .scen  (SCEN),
      .clear (cnt_clr),
      .count (cnt)
   );

   assign atk_press = btn_attack & ~atk_prev;
   assign act_state = state;

   // Last-frame count for the phase currently running.
   always_comb begin
      term_sel = '0;
      case (state)
         ST_JUMP:        term_sel = TC_JUMP;
         ST_ATK_STARTUP: term_sel = TC_STARTUP;
         ST_ATK_ACTIVE:  term_sel = TC_ACTIVE;
         ST_ATK_RECOVER: term_sel = TC_RECOVER;
         ST_HITSTUN:     term_sel = TC_HITSTUN;
         default:        term_sel = '0;
      endcase
   end
   assign cnt_term = (cnt == term_sel);

`ifdef ATTACK_BUFFER_EN
   localparam int unsigned HS_LEN = (HITSTUN_FRAMES == 0) ? 1 : HITSTUN_FRAMES;
   localparam logic [CNT_WIDTH-1:0] BUF_OPEN =
      CNT_WIDTH'((HS_LEN > ATK_BUF_WINDOW) ? HS_LEN - ATK_BUF_WINDOW : 0);

   logic atk_buf, atk_buf_n;

   // Capture presses made while locked out; a hit always discards the press.
   always_comb begin
      atk_buf_n = atk_buf;
      if (atk_press & ((state == ST_ATK_RECOVER) | (state == ST_JUMP) |
                       ((state == ST_HITSTUN) & (cnt >= BUF_OPEN))))
         atk_buf_n = 1'b1;
      if (((state == ST_IDLE) | (state == ST_MOVE)) & ~jump_active)
         atk_buf_n = 1'b0;
      if (hit_taken)
         atk_buf_n = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     atk_buf <= 1'b0;
      else if (SCEN) atk_buf <= atk_buf_n;
   end
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      restart     = 1'b0;
      takeoff     = 1'b0;
      jump_seen_n = jump_seen;
`ifdef ATTACK_BUFFER_EN
      atk_go      = (atk_press | atk_buf) & ~jump_active;
`else
      atk_go      = atk_press & ~jump_active;
`endif
      case (state)
         ST_IDLE, ST_MOVE: begin
            if (hit_taken)                 state_n = ST_HITSTUN;
            else if (atk_go)               state_n = ST_ATK_STARTUP;
            else if (btn_jump) begin
               state_n     = ST_JUMP;
               takeoff     = 1'b1;
               jump_seen_n = 1'b0;
            end
            else if (btn_left ^ btn_right) state_n = ST_MOVE;
            else                           state_n = ST_IDLE;
         end
         ST_JUMP: begin
            // Landing is an airborne-then-grounded edge from the mover.
            if (hit_taken)                                 state_n = ST_HITSTUN;
            else if ((jump_seen & ~jump_active) | cnt_term) state_n = ST_IDLE;
            else                                           jump_seen_n = jump_seen | jump_active;
         end
         ST_ATK_STARTUP: begin
            if (hit_taken)     state_n = ST_HITSTUN;
            else if (cnt_term) state_n = ST_ATK_ACTIVE;
         end
         ST_ATK_ACTIVE: begin
            if (hit_taken)     state_n = ST_HITSTUN;
            else if (cnt_term) state_n = ST_ATK_RECOVER;
         end
         ST_ATK_RECOVER: begin
            if (hit_taken)     state_n = ST_HITSTUN;
            else if (cnt_term) state_n = ST_IDLE;
         end
         ST_HITSTUN: begin
            if (hit_taken) begin
               state_n = ST_HITSTUN;
               restart = 1'b1;
            end
            else if (cnt_term) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase

      cnt_clr = restart | (state_n != state);

      move_enable_n = (state_n == ST_IDLE) | (state_n == ST_MOVE) | (state_n == ST_JUMP) |
                      ((state_n == ST_HITSTUN) & jump_active);
      move_left_n   = ((state_n == ST_MOVE) | takeoff) & btn_left;
      move_right_n  = ((state_n == ST_MOVE) | takeoff) & btn_right;
      jump_n        = takeoff;
      hitbox_n      = (state_n == ST_ATK_ACTIVE);
      busy_n        = (state_n == ST_ATK_STARTUP) | (state_n == ST_ATK_ACTIVE) |
                      (state_n == ST_ATK_RECOVER) | (state_n == ST_HITSTUN);
   end

   // State and output registers, updated once per frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         atk_prev      <= 1'b0;
         jump_seen     <= 1'b0;
         move_enable   <= 1'b0;
         move_left     <= 1'b0;
         move_right    <= 1'b0;
         jump          <= 1'b0;
         hitbox_active <= 1'b0;
         busy          <= 1'b0;
      end else if (SCEN) begin
         state         <= state_n;
         atk_prev      <= btn_attack;
         jump_seen     <= jump_seen_n;
         move_enable   <= move_enable_n;
         move_left     <= move_left_n;
         move_right    <= move_right_n;
         jump          <= jump_n;
         hitbox_active <= hitbox_n;
         busy          <= busy_n;
      end
   end

endmodule
